// File: rtl/decode_issue_ctrl_if.sv
// Fetch-to-decode issue bus: instruction stream in, classified head entry out.
// The package carries the instruction-format type shared with the immediate builder.
package decode_issue_pkg;
  typedef enum logic [2:0] {
    R_TYPE = 3'd0,
    I_TYPE = 3'd1,
    S_TYPE = 3'd2,
    B_TYPE = 3'd3,
    U_TYPE = 3'd4,
    J_TYPE = 3'd5
  } inst_format_t;
endpackage

interface decode_issue_ctrl_if #(
  parameter int DEPTH = 2,
  parameter int PC_W  = 32
);
  import decode_issue_pkg::*;

  // Handshake: a transfer happens on a rising clk edge where valid and ready are
  // both high; valid never waits for ready, and payload is stable while valid is high.
  logic                     in_valid;
  logic                     in_ready;
  logic [31:0]              in_instr;
  logic [PC_W-1:0]          in_pc;
  logic                     out_valid;
  logic                     out_ready;
  logic [31:0]              out_instr;
  logic [PC_W-1:0]          out_pc;
  inst_format_t             out_fmt;
  logic                     out_illegal;
  logic                     flush;
  logic [$clog2(DEPTH):0]   occupancy;

  modport master (
    output in_valid, in_instr, in_pc, out_ready, flush,
    input  in_ready, out_valid, out_instr, out_pc, out_fmt, out_illegal, occupancy
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready, flush,
    output in_ready, out_valid, out_instr, out_pc, out_fmt, out_illegal, occupancy
  );
endinterface

// File: rtl/decode_issue_ctrl.sv
// Small issue FIFO between fetch and decode; classifies the head opcode into
// an instruction format for the immediate builder and flags illegal opcodes.
module decode_issue_ctrl
  import decode_issue_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PC_W  = 32
) (
  input logic                clk,
  input logic                rst_n,
  decode_issue_ctrl_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic   in_ready;
  logic   out_valid;
  logic   push;
  logic   pop;
  entry_t head;

  function automatic void classify(input logic [31:0] instr,
                                   output inst_format_t fmt,
                                   output logic illegal);
    fmt     = R_TYPE;
    illegal = 1'b0;
    case (instr[6:0])
      7'b0110011:                                     fmt = R_TYPE;
      7'b0010011, 7'b0000011, 7'b1100111,
      7'b1110011, 7'b0001111:                         fmt = I_TYPE;
      7'b0100011:                                     fmt = S_TYPE;
      7'b1100011:                                     fmt = B_TYPE;
      7'b0110111, 7'b0010111:                         fmt = U_TYPE;
      7'b1101111:                                     fmt = J_TYPE;
      default:                                        illegal = 1'b1;
    endcase
  endfunction

  // in_ready depends only on registered count, so out_ready never reaches it.
  assign in_ready  = (count_q < CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = bus.in_valid & in_ready;
  assign pop       = out_valid & bus.out_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = '{pc: bus.in_pc, instr: bus.in_instr};
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '{pc: '0, instr: NOP};
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  // An empty FIFO presents a NOP so the immediate builder sees a benign I-type word.
  always_comb begin
    head = '{pc: '0, instr: NOP};
    if (out_valid) begin
      head = mem_q[rd_ptr_q];
    end
  end

  always_comb begin
    bus.out_fmt     = I_TYPE;
    bus.out_illegal = 1'b0;
    classify(head.instr, bus.out_fmt, bus.out_illegal);
    if (head.instr[1:0] != 2'b11) begin
      bus.out_fmt     = R_TYPE;
      bus.out_illegal = 1'b1;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_instr = head.instr;
  assign bus.out_pc    = head.pc;
  assign bus.occupancy = count_q;

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Directed bench for decode_issue_ctrl: handshake, ordering, flush, decode and reset.
module tb_decode_issue_ctrl;
  import decode_issue_pkg::*;

  localparam int DEPTH = 2;
  localparam int PC_W  = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  logic [31:0] exp_q[$];

  decode_issue_ctrl_if #(.DEPTH(DEPTH), .PC_W(PC_W)) bus ();

  decode_issue_ctrl #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic rdy, input logic fl);
    bus.in_valid  = v;
    bus.in_instr  = instr;
    bus.in_pc     = pc;
    bus.out_ready = rdy;
    bus.flush     = fl;
  endtask

  task automatic test_reset();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    n_checks++;
    if ({bus.in_ready, bus.out_valid, bus.occupancy} !== {1'b1, 1'b0, 2'd0}) begin
      n_fail++;
      $display("FAIL reset_ctrl: got rdy/vld/occ %b/%b/%0d expected 1/0/0",
               bus.in_ready, bus.out_valid, bus.occupancy);
    end
    n_checks++;
    if ({bus.out_instr, bus.out_pc, bus.out_fmt, bus.out_illegal} !== {NOP, 32'h0, I_TYPE, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_head: got %h pc %h fmt %0d ill %b expected 00000013 pc 0 fmt I ill 0",
               bus.out_instr, bus.out_pc, bus.out_fmt, bus.out_illegal);
    end
    #10;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    drive(1'b1, 32'h0050_0093, 32'h100, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL no_bypass: got out_valid %b expected 0", bus.out_valid);
    end
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    n_checks++;
    if ({bus.out_valid, bus.out_instr, bus.out_pc, bus.out_fmt, bus.out_illegal, bus.occupancy}
        !== {1'b1, 32'h0050_0093, 32'h100, I_TYPE, 1'b0, 2'd1}) begin
      n_fail++;
      $display("FAIL single_head: got v%b %h pc %h fmt %0d ill %b occ %0d expected v1 00500093 pc 100 fmt I ill 0 occ 1",
               bus.out_valid, bus.out_instr, bus.out_pc, bus.out_fmt, bus.out_illegal, bus.occupancy);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    n_checks++;
    if ({bus.out_valid, bus.occupancy, bus.out_instr} !== {1'b0, 2'd0, NOP}) begin
      n_fail++;
      $display("FAIL single_pop: got v%b occ %0d %h expected v0 occ 0 00000013",
               bus.out_valid, bus.occupancy, bus.out_instr);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0]  tbl [4];
    inst_format_t fmt [4];
    tbl[0] = 32'h0011_2623; fmt[0] = S_TYPE;
    tbl[1] = 32'hFE00_0EE3; fmt[1] = B_TYPE;
    tbl[2] = 32'h1234_50B7; fmt[2] = U_TYPE;
    tbl[3] = 32'h0080_00EF; fmt[3] = J_TYPE;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        drive(1'b1, tbl[i], 32'h200 + 32'(4 * i), 1'b1, 1'b0);
        exp_q.push_back(tbl[i]);
      end else begin
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      end
      step();
      if (i < 4) begin
        n_checks++;
        if ({bus.out_valid, bus.out_instr, bus.out_fmt, bus.out_pc}
            !== {1'b1, exp_q[0], fmt[i], 32'h200 + 32'(4 * i)}) begin
          n_fail++;
          $display("FAIL b2b_head%0d: got v%b %h fmt %0d pc %h expected v1 %h fmt %0d pc %h",
                   i, bus.out_valid, bus.out_instr, bus.out_fmt, bus.out_pc,
                   exp_q[0], fmt[i], 32'h200 + 32'(4 * i));
        end
        void'(exp_q.pop_front());
      end
    end
    bus.out_ready = 1'b0;
    n_checks++;
    if ({bus.out_valid, bus.occupancy} !== {1'b0, 2'd0}) begin
      n_fail++;
      $display("FAIL b2b_drain: got v%b occ %0d expected v0 occ 0", bus.out_valid, bus.occupancy);
    end
  endtask

  task automatic test_full_wrap();
    drive(1'b1, 32'h00A0_0113, 32'h300, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h0020_81B3, 32'h304, 1'b0, 1'b0);
    step();
    n_checks++;
    if ({bus.in_ready, bus.occupancy, bus.out_instr} !== {1'b0, 2'd2, 32'h00A0_0113}) begin
      n_fail++;
      $display("FAIL full_state: got rdy %b occ %0d head %h expected rdy 0 occ 2 head 00a00113",
               bus.in_ready, bus.occupancy, bus.out_instr);
    end
    drive(1'b1, 32'h0000_100F, 32'h308, 1'b0, 1'b0);
    step();
    n_checks++;
    if ({bus.occupancy, bus.out_instr} !== {2'd2, 32'h00A0_0113}) begin
      n_fail++;
      $display("FAIL full_refuse: got occ %0d head %h expected occ 2 head 00a00113",
               bus.occupancy, bus.out_instr);
    end
    bus.out_ready = 1'b1;
    step();
    n_checks++;
    if ({bus.occupancy, bus.in_ready, bus.out_instr, bus.out_fmt} !== {2'd1, 1'b1, 32'h0020_81B3, R_TYPE}) begin
      n_fail++;
      $display("FAIL full_pop_refuse: got occ %0d rdy %b head %h fmt %0d expected occ 1 rdy 1 head 002081b3 fmt R",
               bus.occupancy, bus.in_ready, bus.out_instr, bus.out_fmt);
    end
    bus.out_ready = 1'b0;
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    n_checks++;
    if ({bus.occupancy, bus.out_instr} !== {2'd2, 32'h0020_81B3}) begin
      n_fail++;
      $display("FAIL wrap_accept: got occ %0d head %h expected occ 2 head 002081b3",
               bus.occupancy, bus.out_instr);
    end
    step();
    n_checks++;
    if ({bus.out_instr, bus.out_pc, bus.out_fmt} !== {32'h0000_100F, 32'h308, I_TYPE}) begin
      n_fail++;
      $display("FAIL wrap_order: got %h pc %h fmt %0d expected 0000100f pc 308 fmt I",
               bus.out_instr, bus.out_pc, bus.out_fmt);
    end
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h0010_0093, 32'h400, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h0020_0113, 32'h404, 1'b1, 1'b1);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    n_checks++;
    if ({bus.occupancy, bus.out_valid, bus.in_ready, bus.out_instr, bus.out_fmt}
        !== {2'd0, 1'b0, 1'b1, NOP, I_TYPE}) begin
      n_fail++;
      $display("FAIL flush_clear: got occ %0d v%b rdy %b %h fmt %0d expected occ 0 v0 rdy 1 00000013 fmt I",
               bus.occupancy, bus.out_valid, bus.in_ready, bus.out_instr, bus.out_fmt);
    end
    drive(1'b1, 32'h0030_0193, 32'h500, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    n_checks++;
    if ({bus.occupancy, bus.out_instr, bus.out_pc} !== {2'd1, 32'h0030_0193, 32'h500}) begin
      n_fail++;
      $display("FAIL flush_restart: got occ %0d %h pc %h expected occ 1 00300193 pc 500",
               bus.occupancy, bus.out_instr, bus.out_pc);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_illegal();
    drive(1'b1, 32'h0000_007F, 32'h600, 1'b0, 1'b0);
    step();
    n_checks++;
    if ({bus.out_illegal, bus.out_fmt, bus.out_instr} !== {1'b1, R_TYPE, 32'h0000_007F}) begin
      n_fail++;
      $display("FAIL illegal_7f: got ill %b fmt %0d %h expected ill 1 fmt R 0000007f",
               bus.out_illegal, bus.out_fmt, bus.out_instr);
    end
    drive(1'b1, 32'h0000_0000, 32'h604, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    n_checks++;
    if ({bus.out_valid, bus.out_illegal, bus.out_fmt, bus.out_pc} !== {1'b1, 1'b1, R_TYPE, 32'h604}) begin
      n_fail++;
      $display("FAIL illegal_zero: got v%b ill %b fmt %0d pc %h expected v1 ill 1 fmt R pc 604",
               bus.out_valid, bus.out_illegal, bus.out_fmt, bus.out_pc);
    end
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_formats();
    logic [31:0]  tbl [9];
    inst_format_t fmt [9];
    logic         ill [9];
    tbl[0] = 32'h0000_2083; fmt[0] = I_TYPE; ill[0] = 1'b0;
    tbl[1] = 32'h0000_8067; fmt[1] = I_TYPE; ill[1] = 1'b0;
    tbl[2] = 32'h0000_0073; fmt[2] = I_TYPE; ill[2] = 1'b0;
    tbl[3] = 32'h0000_1017; fmt[3] = U_TYPE; ill[3] = 1'b0;
    tbl[4] = 32'h0000_000F; fmt[4] = I_TYPE; ill[4] = 1'b0;
    tbl[5] = 32'h40B5_0533; fmt[5] = R_TYPE; ill[5] = 1'b0;
    tbl[6] = 32'h00A1_2023; fmt[6] = S_TYPE; ill[6] = 1'b0;
    tbl[7] = 32'h0000_0031; fmt[7] = R_TYPE; ill[7] = 1'b1;
    tbl[8] = 32'h0000_005B; fmt[8] = R_TYPE; ill[8] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i < 9) begin
        drive(1'b1, tbl[i], 32'h700 + 32'(4 * i), 1'b1, 1'b0);
        exp_q.push_back(tbl[i]);
      end else begin
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      end
      step();
      if (i < 9) begin
        n_checks++;
        if ({bus.out_instr, bus.out_fmt, bus.out_illegal} !== {exp_q[0], fmt[i], ill[i]}) begin
          n_fail++;
          $display("FAIL fmt_%0d: got %h fmt %0d ill %b expected %h fmt %0d ill %b",
                   i, bus.out_instr, bus.out_fmt, bus.out_illegal, exp_q[0], fmt[i], ill[i]);
        end
        void'(exp_q.pop_front());
      end
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    drive(1'b1, 32'h0040_0213, 32'h800, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h0050_0293, 32'h804, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    n_checks++;
    if (bus.occupancy !== 2'd2) begin
      n_fail++;
      $display("FAIL areset_fill: got occ %0d expected 2", bus.occupancy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.in_ready, bus.out_valid, bus.occupancy, bus.out_instr, bus.out_pc, bus.out_fmt, bus.out_illegal}
        !== {1'b1, 1'b0, 2'd0, NOP, 32'h0, I_TYPE, 1'b0}) begin
      n_fail++;
      $display("FAIL areset_clear: got rdy %b v%b occ %0d %h pc %h fmt %0d ill %b expected rdy 1 v0 occ 0 00000013 pc 0 fmt I ill 0",
               bus.in_ready, bus.out_valid, bus.occupancy, bus.out_instr, bus.out_pc,
               bus.out_fmt, bus.out_illegal);
    end
    #2;
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_full_wrap();
    test_flush();
    test_illegal();
    test_formats();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
